sra_multistep_shifter: RTL and testbench

- Sequential arithmetic right shifter for shift amounts wider than the 2-bit step range.
- Captures an N-bit signed operand and shift amount over a valid/ready handshake.
- Shifts iteratively, at most 3 positions per clock, through a combinational step shifter.
- Returns the result over a valid/ready handshake. Sits between the operand register file and the ALU result mux.

---
 rtl/sra_pkg.sv | 15 +
 rtl/sra_step.sv | 32 +++
 rtl/sra_multistep_shifter.sv | 132 +++++++++++++
 tb/tb_sra_multistep_shifter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sra_pkg.sv
// Shared types and constants for the multi-step arithmetic right shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sra_state_t;

    // Largest distance the single-cycle step shifter can cover.
    localparam int STEP_MAX = 3;

endpackage

// File: rtl/sra_step.sv
// Combinational N-bit arithmetic right shift by 0..3 with lost-bit OR (lost-bit flag only with SRA_STICKY_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module sra_step
    import sra_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] din,
    input  logic [1:0]   amt,
`ifdef SRA_STICKY_EN
    output logic         lost_bits_or,
`endif
    output logic [N-1:0] dout
);

    // Sign-filling shift; the sign bit is replicated into the vacated MSBs.
    always_comb begin
        dout = $signed(din) >>> amt;
    end

`ifdef SRA_STICKY_EN
    logic [N-1:0] lost_mask;

    // Mask of the amt low-order bits that fall off the bottom this step.
    always_comb begin
        lost_mask    = (N'(1) << amt) - N'(1);
        lost_bits_or = |(din & lost_mask);
    end
`endif

endmodule

// File: rtl/sra_multistep_shifter.sv
// Iterative arithmetic right shifter: up to STEP_MAX positions per clock; sticky tracking with SRA_STICKY_EN.
// Latency: max(1, ceil(shamt/3)) cycles from acceptance to out_valid.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE, nothing queued.
module sra_multistep_shifter
    import sra_pkg::*;
#(
    parameter int N  = 5,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_sticky,
    output logic          busy
);

    sra_state_t    state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] rem_q, rem_d;
    logic [1:0]    step_amt;
    logic [N-1:0]  step_dout;

`ifdef SRA_STICKY_EN
    logic          sticky_q, sticky_d;
    logic          step_lost;
`endif

    // Per-cycle distance: the remaining amount, clipped to what one step can do.
    always_comb begin
        if (rem_q >= SW'(STEP_MAX)) begin
            step_amt = 2'(STEP_MAX);
        end else begin
            step_amt = rem_q[1:0];
        end
    end

    sra_step #(
        .N (N)
    ) u_step (
        .din          (data_q),
        .amt          (step_amt),
`ifdef SRA_STICKY_EN
        .lost_bits_or (step_lost),
`endif
        .dout         (step_dout)
    );

    // Next-state and datapath updates for the IDLE -> SHIFT -> DONE handshake loop.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
`ifdef SRA_STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_shamt;
`ifdef SRA_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A zero amount still spends one cycle here with a step of 0.
                data_d = step_dout;
                rem_d  = rem_q - SW'(step_amt);
`ifdef SRA_STICKY_EN
                sticky_d = sticky_q | step_lost;
`endif
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

`ifdef SRA_STICKY_EN
    // Sticky flag register, cleared on reset and on each new acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif

    // Outputs decode straight from registered state; no path from in_* to out_*.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
        out_data  = data_q;
`ifdef SRA_STICKY_EN
        out_sticky = sticky_q;
`else
        out_sticky = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sra_multistep_shifter.sv
// Self-checking bench for sra_multistep_shifter: directed table, corner sequences, random vs reference model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_sra_multistep_shifter;

    localparam int N  = 5;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_sticky;
    logic          busy;

    int checks = 0;
    int errors = 0;

    sra_multistep_shifter #(
        .N  (N),
        .SW (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  data;
        logic [SW-1:0] shamt;
        logic [N-1:0]  exp_data;
        logic          exp_sticky;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sticky only reported when the feature is compiled in.
    function automatic logic sticky_exp(input logic s);
`ifdef SRA_STICKY_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // Reference: floor division by 2^s; sticky is whether the remainder is nonzero.
    function automatic void ref_model(input logic [N-1:0] d, input int s,
                                      output logic [N-1:0] q, output logic st, output int lat);
        int v, dv, r, qi;
        v  = int'($signed(d));
        dv = 1 << s;
        r  = ((v % dv) + dv) % dv;
        qi = (v - r) / dv;
        q  = N'(qi);
        st = (r != 0);
        lat = (s == 0) ? 1 : (s + 2) / 3;
    endfunction

    // Offer one operand from the cycle after an edge and consume the acceptance edge.
    task automatic start_txn(input logic [N-1:0] d, input logic [SW-1:0] s);
        chk("in_ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [N-1:0] d, input logic [SW-1:0] s,
                                 input logic [N-1:0] ed, input logic es, input int el);
        int lat;
        start_txn(d, s);
        wait_done(lat);
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_data"}, int'(out_data), int'(ed));
        chk({tag, "_sticky"}, int'(out_sticky), int'(sticky_exp(es)));
        release_result();
    endtask

    initial begin
        logic [N-1:0] d0, rd;
        logic         s0, rs;
        int           rl, lat;
        bit           saw_valid;

        vecs[0] = '{5'b01010, 3'd2, 5'b00010, 1'b1, 1};
        vecs[1] = '{5'b10110, 3'd5, 5'b11111, 1'b1, 2};
        vecs[2] = '{5'b11111, 3'd0, 5'b11111, 1'b0, 1};
        vecs[3] = '{5'b01010, 3'd7, 5'b00000, 1'b1, 3};
        vecs[4] = '{5'b10000, 3'd3, 5'b11110, 1'b0, 1};
        vecs[5] = '{5'b01111, 3'd4, 5'b00000, 1'b1, 2};
        vecs[6] = '{5'b10000, 3'd6, 5'b11111, 1'b1, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_sticky", int'(out_sticky), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt,
                          vecs[i].exp_data, vecs[i].exp_sticky, vecs[i].exp_lat);
        end

        // Backpressure: result held, new request ignored while in DONE.
        start_txn(5'b01010, 3'd2);
        wait_done(lat);
        d0 = out_data;
        s0 = out_sticky;
        chk("bp_first_data", int'(d0), int'(5'b00010));
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            in_data  = 5'b00001;
            in_shamt = 3'd1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
            chk($sformatf("bp_data_c%0d", c), int'(out_data), int'(5'b00010));
            chk($sformatf("bp_sticky_c%0d", c), int'(out_sticky), int'(sticky_exp(1'b1)));
            chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
        end
        release_result();
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_busy_after", int'(busy), 0);
        chk("bp_no_capture", int'(out_valid), 0);

        // Reset in the middle of a shamt-7 transaction.
        start_txn(5'b01010, 3'd7);
        @(posedge clk);
        #1;
        chk("mid_busy_shift", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_data", int'(out_data), 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("rst_mid_dropped", int'(saw_valid), 0);
        run_and_check("post_rst", 5'b10110, 3'd5, 5'b11111, 1'b1, 2);

        // Random operands against the arithmetic reference model.
        for (int t = 0; t < 150; t++) begin
            d0 = N'($urandom_range(0, (1 << N) - 1));
            rl = $urandom_range(0, (1 << SW) - 1);
            ref_model(d0, rl, rd, rs, lat);
            run_and_check($sformatf("rnd%0d", t), d0, SW'(rl), rd, rs, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
